pipe_control: RTL

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/y86_pkg.sv | 36 +++
 rtl/pipe_control.sv | 111 +++++++++++
 2 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Package    : y86_pkg
// Description: Shared Y86-64 icode and status encodings, and the pipeline
//              controller state type.
// Revision   : 1.0 - initial release
// ============================================================================
package y86_pkg;

  localparam logic [3:0] c_NOP    = 4'h1;
  localparam logic [3:0] c_MRMOVQ = 4'h5;
  localparam logic [3:0] c_OPQ    = 4'h6;
  localparam logic [3:0] c_JXX    = 4'h7;
  localparam logic [3:0] c_RET    = 4'h9;
  localparam logic [3:0] c_POPQ   = 4'hB;
  localparam logic [3:0] c_RNONE  = 4'hF;

  localparam logic [2:0] c_AOK = 3'd1;
  localparam logic [2:0] c_HLT = 3'd2;
  localparam logic [2:0] c_ADR = 3'd3;
  localparam logic [2:0] c_INS = 3'd4;

  // The ret sequence owes two further bubble cycles after the detect cycle.
  localparam logic [1:0] c_RET_EXTRA = 2'd2;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pipe_state_t;

  function automatic logic is_load(input logic [3:0] icode);
    return (icode == c_MRMOVQ) || (icode == c_POPQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_control.sv
`default_nettype none
// ============================================================================
// Module     : pipe_control
// Description: Y86-64 pipeline hazard controller: stall/bubble generation,
//              ret sequencing, halt state and an E-bubble event counter.
// Revision   : 1.0 - initial release
// ============================================================================
module pipe_control
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_dstM,
  input  logic        e_cnd,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        W_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        set_cc,
  output logic        halted,
  output logic [31:0] bubble_count
);

  pipe_state_t r_state;
  pipe_state_t w_state_nxt;
  logic [1:0]  r_rc;
  logic [1:0]  w_rc_nxt;
  logic [31:0] r_bubble_count;
  logic        w_lu;
  logic        w_mp;
  logic        w_rs;
  logic        w_rp;
  logic        w_unused;

  assign w_unused = ^M_icode;

  assign w_lu = is_load(E_icode) && (E_dstM != c_RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_mp = (E_icode == c_JXX) && !e_cnd;
  // A ret colliding with load/use is not accepted; it is re-detected next cycle.
  assign w_rs = (D_icode == c_RET) && !w_lu && !w_mp && (r_rc == 2'd0);
  assign w_rp = w_rs || (r_rc != 2'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = r_rc;
    F_stall     = 1'b0;
    D_stall     = 1'b0;
    W_stall     = 1'b0;
    D_bubble    = 1'b0;
    E_bubble    = 1'b0;
    M_bubble    = 1'b0;
    set_cc      = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (r_state == ST_HALT) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
      halted  = 1'b1;
    end else begin
      F_stall  = w_lu || w_rp;
      D_stall  = w_lu;
      D_bubble = w_mp || (w_rp && !w_lu);
      E_bubble = w_mp || w_lu;
      M_bubble = (m_stat != c_AOK) || (W_stat != c_AOK);
      set_cc   = (E_icode == c_OPQ) && (m_stat == c_AOK) && (W_stat == c_AOK);
      if (w_mp) begin
        w_rc_nxt = 2'd0;
      end else if (r_rc != 2'd0) begin
        w_rc_nxt = r_rc - 2'd1;
      end else if (w_rs) begin
        w_rc_nxt = c_RET_EXTRA;
      end
      if (W_stat != c_AOK) begin
        w_state_nxt = ST_HALT;
      end
    end
  end

  // Reset clears the counter even though E_bubble is forced high during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_rc           <= 2'd0;
      r_bubble_count <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rc    <= w_rc_nxt;
      if (E_bubble && (r_bubble_count != 32'hFFFF_FFFF)) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign bubble_count = r_bubble_count;

endmodule
`default_nettype wire
